// File: rtl/sys_defs.sv
// Shared system definitions: bus command encoding, address width and the
// per-tag ownership record used by the memory arbiter.
package sys_defs;

    localparam int XLEN      = 32;
    localparam int SD        = 1;
    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // owner: 0 = Icache, 1 = Dcache; stale marks Icache refills killed by a squash
    typedef struct packed {
        logic valid;
        logic owner;
        logic stale;
    } MEM_TAG_ENTRY;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/memory side signals of the arbiter. The arbiter takes the master
// modport; the caches and memory model sit on the slave modport.
interface mem_arbiter_if import sys_defs::*; #(
    parameter int TAG_W = MEM_TAG_W
) ();
    logic               squash_in;
    BUS_COMMAND         icache2arb_command;
    logic [XLEN-1:0]    icache2arb_addr;
    BUS_COMMAND         dcache2arb_command;
    logic [XLEN-1:0]    dcache2arb_addr;
    logic [63:0]        dcache2arb_data;
    BUS_COMMAND         proc2mem_command;
    logic [XLEN-1:0]    proc2mem_addr;
    logic [63:0]        proc2mem_data;
    logic [TAG_W-1:0]   mem2proc_response;
    logic [63:0]        mem2proc_data;
    logic [TAG_W-1:0]   mem2proc_tag;
    logic [TAG_W-1:0]   arb2icache_response;
    logic [63:0]        arb2icache_data;
    logic [TAG_W-1:0]   arb2icache_tag;
    logic [TAG_W-1:0]   arb2dcache_response;
    logic [63:0]        arb2dcache_data;
    logic [TAG_W-1:0]   arb2dcache_tag;

    modport master (
        input  squash_in, icache2arb_command, icache2arb_addr,
               dcache2arb_command, dcache2arb_addr, dcache2arb_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
               arb2icache_response, arb2icache_data, arb2icache_tag,
               arb2dcache_response, arb2dcache_data, arb2dcache_tag
    );

    modport slave (
        output squash_in, icache2arb_command, icache2arb_addr,
               dcache2arb_command, dcache2arb_addr, dcache2arb_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
               arb2icache_response, arb2icache_data, arb2icache_tag,
               arb2dcache_response, arb2dcache_data, arb2dcache_tag
    );
endinterface

// File: rtl/mem_tag_table.sv
// Outstanding-tag ownership table. Entry 0 is never written, so tag 0
// always reads as invalid. Priority per entry at the edge:
// new issue write > return clear > squash stale-mark.
module mem_tag_table import sys_defs::*; #(
    parameter int TAG_W = MEM_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_idx,
    input  logic             wr_owner,
    input  logic             clr_en,
    input  logic [TAG_W-1:0] clr_idx,
    input  logic             squash,
    input  logic [TAG_W-1:0] rd_idx,
    output MEM_TAG_ENTRY     rd_entry
);
    localparam int DEPTH = 1 << TAG_W;

    MEM_TAG_ENTRY entry_q [DEPTH];

    // Per-entry update: write beats clear so a reused tag survives its own return
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en && wr_idx == TAG_W'(i))
                    entry_q[i] <= '{valid: 1'b1, owner: wr_owner, stale: 1'b0};
                else if (clr_en && clr_idx == TAG_W'(i))
                    entry_q[i] <= '0;
                else if (squash && entry_q[i].valid && entry_q[i].owner == OWNER_I)
                    entry_q[i].stale <= 1'b1;
            end
        end
    end

    assign rd_entry = entry_q[rd_idx];
endmodule

// File: rtl/mem_arbiter.sv
// Icache/Dcache arbiter for the shared memory bus. Dcache has priority,
// bounded by a streak counter so Icache refills cannot starve; returning
// data is steered through the tag ownership table.
module mem_arbiter import sys_defs::*; #(
    parameter int TAG_W      = MEM_TAG_W,
    parameter int STREAK_MAX = 4
) (
    input  logic           clock,
    input  logic           reset,
    mem_arbiter_if.master  bus
);
    localparam int SW = $clog2(STREAK_MAX + 1);

    logic [SW-1:0] streak_cnt;
    logic          i_req, d_req, grant_i, grant_d, streak_full;
    logic          tbl_wr, ret_hit;
    MEM_TAG_ENTRY  ret_entry;

    // An Icache store is meaningless and is treated as no request
    assign i_req       = (bus.icache2arb_command == BUS_LOAD);
    assign d_req       = (bus.dcache2arb_command == BUS_LOAD) ||
                         (bus.dcache2arb_command == BUS_STORE);
    assign streak_full = (streak_cnt == SW'(STREAK_MAX));
    assign grant_i     = i_req && (!d_req || streak_full);
    assign grant_d     = d_req && !grant_i;

    // Drive the bus with the winner and hand the issue tag only to it
    always_comb begin
        bus.proc2mem_command    = BUS_NONE;
        bus.proc2mem_addr       = '0;
        bus.proc2mem_data       = '0;
        bus.arb2icache_response = '0;
        bus.arb2dcache_response = '0;
        if (grant_d) begin
            bus.proc2mem_command    = bus.dcache2arb_command;
            bus.proc2mem_addr       = bus.dcache2arb_addr;
            bus.proc2mem_data       = bus.dcache2arb_data;
            bus.arb2dcache_response = bus.mem2proc_response;
        end else if (grant_i) begin
            bus.proc2mem_command    = BUS_LOAD;
            bus.proc2mem_addr       = bus.icache2arb_addr;
            bus.arb2icache_response = bus.mem2proc_response;
        end
    end

    // Count Dcache wins while the Icache is waiting; saturate at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            streak_cnt <= '0;
        else if (!i_req || grant_i)
            streak_cnt <= '0;
        else if (grant_d && !streak_full)
            streak_cnt <= streak_cnt + SW'(1);
    end

    // Only accepted loads expect a return; stores are never tracked
    assign tbl_wr  = (grant_i || (grant_d && bus.dcache2arb_command == BUS_LOAD)) &&
                     (bus.mem2proc_response != '0);
    assign ret_hit = (bus.mem2proc_tag != '0) && ret_entry.valid;

    mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (tbl_wr),
        .wr_idx   (bus.mem2proc_response),
        .wr_owner (grant_d),
        .clr_en   (ret_hit),
        .clr_idx  (bus.mem2proc_tag),
        .squash   (bus.squash_in),
        .rd_idx   (bus.mem2proc_tag),
        .rd_entry (ret_entry)
    );

    // Steer the returning tag to its owner; stale Icache refills are dropped
    always_comb begin
        bus.arb2icache_tag  = '0;
        bus.arb2dcache_tag  = '0;
        bus.arb2icache_data = bus.mem2proc_data;
        bus.arb2dcache_data = bus.mem2proc_data;
        if (ret_hit) begin
            if (ret_entry.owner == OWNER_D)
                bus.arb2dcache_tag = bus.mem2proc_tag;
            else if (!ret_entry.stale)
                bus.arb2icache_tag = bus.mem2proc_tag;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: each cycle's expected bus and
// cache-side outputs are queued with the stimulus, then popped and compared
// just before the rising edge.
module tb_mem_arbiter;
    import sys_defs::*;

    localparam logic [XLEN-1:0] IA = 32'h0000_1000;
    localparam logic [XLEN-1:0] DA = 32'h0000_2000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        BUS_COMMAND      cmd;
        logic [XLEN-1:0] addr;
        logic [63:0]     data;
        logic [3:0]      ir, dr, it, dt;
        logic [63:0]     rdata;
    } exp_t;

    exp_t sb[$];

    mem_arbiter_if #(.TAG_W(4)) bus ();

    mem_arbiter #(.TAG_W(4), .STREAK_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic ck(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and return all inputs to idle
    task automatic go();
        @(negedge clock);
        bus.squash_in          = 1'b0;
        bus.icache2arb_command = BUS_NONE;
        bus.icache2arb_addr    = '0;
        bus.dcache2arb_command = BUS_NONE;
        bus.dcache2arb_addr    = '0;
        bus.dcache2arb_data    = '0;
        bus.mem2proc_response  = '0;
        bus.mem2proc_data      = '0;
        bus.mem2proc_tag       = '0;
    endtask

    task automatic expect_out(input string name, input BUS_COMMAND c, input logic [XLEN-1:0] a,
                              input logic [63:0] d, input logic [3:0] ir, input logic [3:0] dr,
                              input logic [3:0] it, input logic [3:0] dt);
        exp_t e;
        e.cmd = c; e.addr = a; e.data = d;
        e.ir = ir; e.dr = dr; e.it = it; e.dt = dt;
        e.rdata = bus.mem2proc_data;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        ck({name, ".cmd"},   64'(bus.proc2mem_command),    64'(e.cmd));
        ck({name, ".addr"},  64'(bus.proc2mem_addr),       64'(e.addr));
        ck({name, ".data"},  bus.proc2mem_data,            e.data);
        ck({name, ".iresp"}, 64'(bus.arb2icache_response), 64'(e.ir));
        ck({name, ".dresp"}, 64'(bus.arb2dcache_response), 64'(e.dr));
        ck({name, ".itag"},  64'(bus.arb2icache_tag),      64'(e.it));
        ck({name, ".dtag"},  64'(bus.arb2dcache_tag),      64'(e.dt));
        ck({name, ".idata"}, bus.arb2icache_data,          e.rdata);
        ck({name, ".ddata"}, bus.arb2dcache_data,          e.rdata);
    endtask

    initial begin
        go();
        expect_out("reset", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); reset = 1'b0;
        expect_out("idle", BUS_NONE, '0, '0, 0, 0, 0, 0);

        // contention: Dcache wins, then Icache alone
        go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA;
        bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = DA; bus.mem2proc_response = 4'd3;
        expect_out("cont_d", BUS_LOAD, DA, '0, 0, 3, 0, 0);
        go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA; bus.mem2proc_response = 4'd1;
        expect_out("cont_i", BUS_LOAD, IA, '0, 1, 0, 0, 0);

        // starvation: four Dcache wins, forced Icache, then Dcache again
        for (int k = 0; k < 6; k++) begin
            go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA;
            bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = DA;
            expect_out($sformatf("starve%0d", k), BUS_LOAD, (k == 4) ? IA : DA, '0, 0, 0, 0, 0);
        end

        // routing
        go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA + 8; bus.mem2proc_response = 4'd2;
        expect_out("rt_iss_i", BUS_LOAD, IA + 8, '0, 2, 0, 0, 0);
        go(); bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = DA + 8; bus.mem2proc_response = 4'd5;
        expect_out("rt_iss_d", BUS_LOAD, DA + 8, '0, 0, 5, 0, 0);
        go(); bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'hAA;
        expect_out("rt_ret5", BUS_NONE, '0, '0, 0, 0, 0, 5);
        go(); bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 64'hBB;
        expect_out("rt_ret2", BUS_NONE, '0, '0, 0, 0, 2, 0);
        go(); bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hCC;
        expect_out("rt_ret3", BUS_NONE, '0, '0, 0, 0, 0, 3);
        go(); bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'hDD;
        expect_out("rt_ret1", BUS_NONE, '0, '0, 0, 0, 1, 0);

        // squash
        go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA; bus.mem2proc_response = 4'd7;
        expect_out("sq_iss7", BUS_LOAD, IA, '0, 7, 0, 0, 0);
        go(); bus.squash_in = 1'b1;
        expect_out("sq_pulse", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); bus.mem2proc_tag = 4'd7; bus.mem2proc_data = 64'h77;
        expect_out("sq_ret7", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); bus.squash_in = 1'b1; bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA;
        bus.mem2proc_response = 4'd8;
        expect_out("sq_iss8", BUS_LOAD, IA, '0, 8, 0, 0, 0);
        go(); bus.mem2proc_tag = 4'd8; bus.mem2proc_data = 64'h88;
        expect_out("sq_ret8", BUS_NONE, '0, '0, 0, 0, 8, 0);
        go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA; bus.mem2proc_response = 4'd6;
        expect_out("sq_iss6", BUS_LOAD, IA, '0, 6, 0, 0, 0);
        go(); bus.squash_in = 1'b1; bus.mem2proc_tag = 4'd6; bus.mem2proc_data = 64'h66;
        expect_out("sq_ret6", BUS_NONE, '0, '0, 0, 0, 6, 0);

        // tag reuse: return and reissue of tag 4 in one cycle
        go(); bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = DA; bus.mem2proc_response = 4'd4;
        expect_out("ru_iss_d", BUS_LOAD, DA, '0, 0, 4, 0, 0);
        go(); bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'h44;
        bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA; bus.mem2proc_response = 4'd4;
        expect_out("ru_swap", BUS_LOAD, IA, '0, 4, 0, 0, 4);
        go(); bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'h45;
        expect_out("ru_ret_i", BUS_NONE, '0, '0, 0, 0, 4, 0);
        go(); bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'h46;
        expect_out("ru_ret_inv", BUS_NONE, '0, '0, 0, 0, 0, 0);

        // stores are untracked; Icache store is ignored
        go(); bus.dcache2arb_command = BUS_STORE; bus.dcache2arb_addr = DA; bus.dcache2arb_data = 64'h1234;
        bus.mem2proc_response = 4'd9;
        expect_out("st_iss", BUS_STORE, DA, 64'h1234, 0, 9, 0, 0);
        go(); bus.mem2proc_tag = 4'd9; bus.mem2proc_data = 64'h99;
        expect_out("st_ret", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); bus.icache2arb_command = BUS_STORE; bus.icache2arb_addr = IA; bus.mem2proc_response = 4'd5;
        expect_out("ist_iss", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'h55;
        expect_out("ist_ret", BUS_NONE, '0, '0, 0, 0, 0, 0);

        // reset with tags 1 and 3 in flight
        go(); bus.icache2arb_command = BUS_LOAD; bus.icache2arb_addr = IA; bus.mem2proc_response = 4'd1;
        expect_out("rs_iss1", BUS_LOAD, IA, '0, 1, 0, 0, 0);
        go(); bus.dcache2arb_command = BUS_LOAD; bus.dcache2arb_addr = DA; bus.mem2proc_response = 4'd3;
        expect_out("rs_iss3", BUS_LOAD, DA, '0, 0, 3, 0, 0);
        go(); reset = 1'b1;
        expect_out("rs_during", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); reset = 1'b0; bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'h11;
        expect_out("rs_ret1", BUS_NONE, '0, '0, 0, 0, 0, 0);
        go(); bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'h33;
        expect_out("rs_ret3", BUS_NONE, '0, '0, 0, 0, 0, 0);

        go();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single processor–memory bus between the instruction cache (fetch refills) and the data cache (loads/stores). Each cycle it picks one requester, drives the bus, and returns the memory's response tag to the requester that won. It records which requester owns each outstanding tag, so returning data (`mem2proc_tag`) is steered to the correct cache. Icache refills issued before a fetch squash are dropped on return.

## Interface
Parameters:
- `TAG_W`, 4: width of the memory tag; tag 0 means "no tag".
- `STREAK_MAX`, 4: consecutive Dcache grants allowed while the Icache waits before the Icache is forced through.

Ports:
- `clock` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `squash_in` input 1: fetch squash; marks all Icache-owned outstanding tags stale.
- `icache2arb_command` input 2: `BUS_NONE`/`BUS_LOAD` (an Icache `BUS_STORE` is treated as `BUS_NONE`).
- `icache2arb_addr` input `XLEN`: 8-byte-aligned refill address.
- `dcache2arb_command` input 2: `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `dcache2arb_addr` input `XLEN`: Dcache address.
- `dcache2arb_data` input 64: store data.
- `proc2mem_command` output 2, `proc2mem_addr` output `XLEN`, `proc2mem_data` output 64: memory bus request.
- `mem2proc_response` input `TAG_W`: issue tag; 0 = request refused.
- `mem2proc_data` input 64, `mem2proc_tag` input `TAG_W`: returning load data and its tag.
- `arb2icache_response` output `TAG_W`, `arb2icache_data` output 64, `arb2icache_tag` output `TAG_W`: Icache view.
- `arb2dcache_response` output `TAG_W`, `arb2dcache_data` output 64, `arb2dcache_tag` output `TAG_W`: Dcache view.

## Operation
- **Grant (combinational, same cycle):**
  - Dcache wins by default when both request.
  - The Icache wins when `streak_cnt == STREAK_MAX` and both request.
  - The single active requester always wins.
- **Bus drive:** the winner's command, address and data go onto the bus. When idle: command `BUS_NONE`, address 0, data 0.
- **Issue tag:** `mem2proc_response` is forwarded only to the winner's `*_response`; the loser sees 0. A loser must hold its request; nothing is queued internally.
- **streak_cnt (0..STREAK_MAX):**
  - Increments on a Dcache grant while the Icache is requesting.
  - Clears on any Icache grant, or when the Icache is not requesting.
  - Saturates at `STREAK_MAX`.
- **Tag table:** 2^TAG_W−1 entries indexed by tag 1..15, each holding {`valid`, `owner` (0=I, 1=D), `stale`}.
  - An accepted `BUS_LOAD` (response ≠ 0) writes {1, winner, 0} at index response.
  - Stores are never recorded.
- **Return routing:** when `mem2proc_tag` ≠ 0 and the entry is valid:
  - owner D: `arb2dcache_tag`/`arb2dcache_data` driven with the tag and data.
  - owner I and not stale: `arb2icache_tag`/`arb2icache_data` driven.
  - owner I and stale: both tag outputs are 0 (data dropped).
  - The entry clears at the edge in every case.
  - A return on an invalid entry is ignored: both tag outputs 0.
  - The non-target `*_tag` is always 0.
  - `*_data` outputs carry `mem2proc_data` unconditionally; consumers qualify on their tag.
- **Squash:** at the edge with `squash_in`=1, every valid owner-I entry sets `stale`. The Icache is still arbitrated normally in the squash cycle.

## Timing
- Request to bus: 0 cycles (combinational). Return to cache: 0 cycles (combinational lookup on registered table).
- Table and `streak_cnt` update on the rising clock edge.
- Reset (asynchronous): table all invalid, `streak_cnt`=0. Outputs go to `BUS_NONE`/0 whenever no input is active.
- Returns arriving after a reset mid-flight hit invalid entries and are dropped.
- **Same-cycle return of tag T and new issue with tag T:** routing uses the old entry; the edge leaves the new entry (write beats clear).
- **Same-cycle squash and Icache issue:** the new entry is not stale. Squash applies only to entries present before the edge.
- **Same-cycle squash and return of an Icache tag:** the return is delivered, since stale is not yet set.
- **Memory refuses (response 0):** no table write; `streak_cnt` still updates per the grant rule.

## Structure
- `BUS_COMMAND` enum, `XLEN` and `SD` come from `sys_defs`.
- Add `MEM_TAG_W` and a `MEM_TAG_ENTRY` struct {`valid`, `owner`, `stale`} to `sys_defs`.
- Sub-module: `mem_tag_table` (write port, clear port, squash-mark, read port).
- The grant and streak logic stay in `mem_arbiter`.

## Test plan
- **Contention:** both load, mem response=3 → Dcache sees response 3, Icache sees 0, bus addr = Dcache addr. Next cycle, Dcache idle → Icache granted.
- **Starvation:** both request for 5 cycles with `STREAK_MAX`=4 → Dcache granted cycles 1–4, Icache granted cycle 5, `streak_cnt` returns to 0.
- **Routing:** Icache load tagged 2, Dcache load tagged 5. Returns tag 5 with data 0xAA, then tag 2 with data 0xBB → `arb2dcache_tag`=5 then `arb2icache_tag`=2, other tag 0 each time.
- **Squash:** Icache tag 7 outstanding, `squash_in` pulse, then return tag 7 → both tag outputs 0. Same-cycle squash and new Icache issue tag 8, then return 8 → `arb2icache_tag`=8.
- **Tag reuse:** return tag 4 (owner D) and a new Icache issue get tag 4 in the same cycle → Dcache receives tag 4. A later return of 4 goes to the Icache.
- **Store and reset:** Dcache store accepted with tag 9, then return tag 9 → ignored. Reset asserted with tags 1 and 3 outstanding, then returns 1 and 3 → both tag outputs 0, bus `BUS_NONE` during reset.
